// File: rtl/clk_power_seq.sv
// rtl/clk_power_seq.sv - clock/oscillator power sequencer for the CPU clock generator
// Owns CLK_ENA/OSC_ENA: cold start, HALT (clocks gated) and STOP (oscillator off) with wake.
module clk_power_seq #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STAB_CYCLES  = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       HALT_REQ,
  input  logic       STOP_REQ,
  input  logic       WAKE,
  input  logic       OSC_STABLE,
  output logic       CLK_ENA,
  output logic       OSC_ENA,
  output logic       RESUMED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OSC_START = 3'd1,
    S_STAB      = 3'd2,
    S_RUN       = 3'd3,
    S_HALT      = 3'd4,
    S_DRAIN     = 3'd5,
    S_STOPPED   = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] STAB_LOAD  = CNT_W'(STAB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resumed_q, resumed_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      resumed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      resumed_q <= resumed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_OSC_START;
      S_OSC_START: begin
        if (OSC_STABLE) begin
          state_d = S_STAB;
          cnt_d   = STAB_LOAD;
        end
      end
      S_STAB: begin
        // Losing stability restarts the whole wait; the count is reloaded on re-entry.
        if (!OSC_STABLE)       state_d = S_OSC_START;
        else if (cnt_q == '0)  state_d = S_RUN;
        else                   cnt_d   = cnt_q - CNT_ONE;
      end
      S_RUN: begin
        if (STOP_REQ) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (HALT_REQ) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (WAKE) state_d = S_RUN;
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_STOPPED;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_STOPPED: begin
        if (WAKE) state_d = S_OSC_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resumed_d = (state_d == S_RUN) && (state_q != S_RUN);

  assign CLK_ENA = (state_q == S_RUN);
  assign OSC_ENA = (state_q == S_OSC_START) || (state_q == S_STAB) || (state_q == S_RUN) ||
                   (state_q == S_HALT) || (state_q == S_DRAIN);
  assign RESUMED = resumed_q;
  assign STATE   = state_q;

endmodule
